// File: rtl/program_loader.sv
// Boot-time program loader sitting in front of main_memory.
// Collects a little-endian byte stream {BASE, COUNT, N words}, writes each word to memory with
// one request outstanding at a time, then publishes per-core entry addresses and pulses start.
// Optional build macro PROGRAM_LOADER_CHECKSUM_EN adds a trailing 32-bit checksum field.
`timescale 1ns/1ps

module program_loader #(
  parameter int unsigned NUM_CORES      = 4,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDRESS_BITS   = 32,
  parameter int unsigned MSG_BITS       = 4,
  parameter int unsigned MEM_INDEX_BITS = 10,
  parameter logic [MSG_BITS-1:0] NO_REQ  = MSG_BITS'(0),
  parameter logic [MSG_BITS-1:0] WB_REQ  = MSG_BITS'(2),
  parameter logic [MSG_BITS-1:0] ACK_MSG = MSG_BITS'(3),
  parameter int unsigned CORE_STRIDE    = 64,
  parameter int unsigned ACK_TIMEOUT    = 255
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              rx_valid,
  input  logic [7:0]                        rx_data,
  output logic                              rx_ready,
  output logic [MSG_BITS-1:0]               msg_out,
  output logic [ADDRESS_BITS-1:0]           address_out,
  output logic [DATA_WIDTH-1:0]             data_out,
  input  logic [MSG_BITS-1:0]               msg_in,
  input  logic [ADDRESS_BITS-1:0]           address_in,
  output logic                              start,
  output logic [NUM_CORES*ADDRESS_BITS-1:0] program_address,
  output logic                              busy,
  output logic                              done,
  output logic                              error
);

  localparam logic [3:0] IDLE         = 4'd0;
  localparam logic [3:0] HDR_BASE     = 4'd1;
  localparam logic [3:0] HDR_COUNT    = 4'd2;
  localparam logic [3:0] DATA_COLLECT = 4'd3;
  localparam logic [3:0] WRITE        = 4'd4;
  localparam logic [3:0] WAIT_ACK     = 4'd5;
  localparam logic [3:0] START        = 4'd6;
  localparam logic [3:0] ERROR        = 4'd7;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  localparam logic [3:0] CHECK        = 4'd8;
  localparam logic [3:0] DATA_END     = CHECK;
`else
  localparam logic [3:0] DATA_END     = START;
`endif

  localparam int unsigned TIMER_BITS = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TIMER_BITS-1:0] TIMER_LAST = TIMER_BITS'(ACK_TIMEOUT - 1);
  localparam logic [33:0] MEM_WORDS = 34'(1) << MEM_INDEX_BITS;

  logic [3:0]                        state_q, state_d;
  logic [1:0]                        byte_cnt_q, byte_cnt_d;
  logic [23:0]                       word_q, word_d;
  logic [31:0]                       base_q, base_d;
  logic [31:0]                       count_q, count_d;
  logic [31:0]                       data_q, data_d;
  logic [31:0]                       idx_q, idx_d;
  logic [TIMER_BITS-1:0]             timer_q, timer_d;
  logic                              done_q, done_d;
  logic [NUM_CORES*ADDRESS_BITS-1:0] pa_q, pa_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [31:0]                       sum_q, sum_d;
`endif

  logic                    take;
  logic                    last_byte;
  logic [31:0]             asm_word;
  logic [ADDRESS_BITS-1:0] wr_addr;
  logic                    ack_match;
  logic                    out_of_range;

  // Byte handshake, LSB-first word assembly and shared address arithmetic
  always_comb begin
    rx_ready = (state_q == IDLE) || (state_q == HDR_BASE) || (state_q == HDR_COUNT) ||
               (state_q == DATA_COLLECT);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    rx_ready = rx_ready || (state_q == CHECK);
`endif
    take         = rx_valid && rx_ready;
    last_byte    = take && (byte_cnt_q == 2'd3);
    // word_q holds the three most recent bytes; the incoming byte completes the word
    asm_word     = {rx_data, word_q};
    wr_addr      = ADDRESS_BITS'((base_q >> 2) + idx_q);
    ack_match    = (msg_in == ACK_MSG) && (address_in == wr_addr);
    out_of_range = ({2'b00, base_q >> 2} + {2'b00, asm_word}) > MEM_WORDS;
  end

  // Next-state and datapath update
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    base_d     = base_q;
    count_d    = count_q;
    data_d     = data_q;
    idx_d      = idx_q;
    timer_d    = timer_q;
    done_d     = done_q;
    pa_d       = pa_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    sum_d      = sum_q;
`endif

    if (take) begin
      byte_cnt_d = byte_cnt_q + 2'd1;
      word_d     = asm_word[31:8];
    end

    case (state_q)
      IDLE: begin
        if (take) begin
          state_d = HDR_BASE;
          done_d  = 1'b0;
        end
      end
      HDR_BASE: begin
        if (last_byte) begin
          base_d  = asm_word;
          state_d = (asm_word[1:0] != 2'b00) ? ERROR : HDR_COUNT;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          sum_d   = asm_word;
`endif
        end
      end
      HDR_COUNT: begin
        if (last_byte) begin
          count_d = asm_word;
          idx_d   = 32'd0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          sum_d   = sum_q + asm_word;
`endif
          if (out_of_range) begin
            state_d = ERROR;
          end else if (asm_word == 32'd0) begin
            state_d = DATA_END;
          end else begin
            state_d = DATA_COLLECT;
          end
        end
      end
      DATA_COLLECT: begin
        if (last_byte) begin
          data_d  = asm_word;
          state_d = WRITE;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          sum_d   = sum_q + asm_word;
`endif
        end
      end
      WRITE: begin
        timer_d = '0;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        // Only an acknowledge for the word in flight counts; anything else is ignored
        if (ack_match) begin
          idx_d   = idx_q + 32'd1;
          state_d = ((idx_q + 32'd1) == count_q) ? DATA_END : DATA_COLLECT;
        end else if (timer_q == TIMER_LAST) begin
          state_d = ERROR;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      CHECK: begin
        if (last_byte) begin
          state_d = (asm_word == sum_q) ? START : ERROR;
        end
      end
`endif
      START: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      ERROR: begin
        state_d = ERROR;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Entry addresses are captured on the way into START so they are valid with the pulse
    if (state_d == START) begin
      for (int unsigned c = 0; c < NUM_CORES; c++) begin
        pa_d[c*ADDRESS_BITS +: ADDRESS_BITS] = ADDRESS_BITS'(base_q + 32'(c * CORE_STRIDE));
      end
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      byte_cnt_q <= 2'd0;
      word_q     <= '0;
      base_q     <= '0;
      count_q    <= '0;
      data_q     <= '0;
      idx_q      <= '0;
      timer_q    <= '0;
      done_q     <= 1'b0;
      pa_q       <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
      base_q     <= base_d;
      count_q    <= count_d;
      data_q     <= data_d;
      idx_q      <= idx_d;
      timer_q    <= timer_d;
      done_q     <= done_d;
      pa_q       <= pa_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

  // Output decode from the registered state
  always_comb begin
    msg_out         = (state_q == WRITE) ? WB_REQ : NO_REQ;
    address_out     = (state_q == WRITE) ? wr_addr : '0;
    data_out        = (state_q == WRITE) ? DATA_WIDTH'(data_q) : '0;
    start           = (state_q == START);
    busy            = (state_q != IDLE) && (state_q != ERROR);
    error           = (state_q == ERROR);
    done            = done_q;
    program_address = pa_q;
  end

endmodule
